// File: rtl/cv32e40p_apu_arbiter.sv
// cv32e40p_apu_arbiter: shares one APU/FPU between NUM_REQ cores, routing each result to its issuer
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   req_apu_*                  per-core request/grant/payload in, per-core rvalid and broadcast result out
//   fpu_*                      single request/grant/payload out to the shared FPU, result in
//   fpu_clk_en_o               FPU clock-gate enable
//   outstanding_o              number of operations in flight
//   orphan_err_o               sticky: a result arrived with nothing in flight
// Build option: define CV32E40P_APU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no RR pointer).
module cv32e40p_apu_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int APU_NARGS       = 3,
    parameter int APU_WOP         = 6,
    parameter int APU_NDSFLAGS    = 15,
    parameter int APU_NUSFLAGS    = 5
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NUM_REQ-1:0]                          req_apu_req_i,
    output logic [NUM_REQ-1:0]                          req_apu_gnt_o,
    input  logic [NUM_REQ-1:0][APU_NARGS-1:0][31:0]     req_apu_operands_i,
    input  logic [NUM_REQ-1:0][APU_WOP-1:0]             req_apu_op_i,
    input  logic [NUM_REQ-1:0][APU_NDSFLAGS-1:0]        req_apu_flags_i,
    output logic [NUM_REQ-1:0]                          req_apu_rvalid_o,
    output logic [31:0]                                 req_apu_result_o,
    output logic [APU_NUSFLAGS-1:0]                     req_apu_rflags_o,
    output logic                                        fpu_req_o,
    input  logic                                        fpu_gnt_i,
    output logic [APU_NARGS-1:0][31:0]                  fpu_operands_o,
    output logic [APU_WOP-1:0]                          fpu_op_o,
    output logic [APU_NDSFLAGS-1:0]                     fpu_flags_o,
    input  logic                                        fpu_rvalid_i,
    input  logic [31:0]                                 fpu_result_i,
    input  logic [APU_NUSFLAGS-1:0]                     fpu_rflags_i,
    output logic                                        fpu_clk_en_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]        outstanding_o,
    output logic                                        orphan_err_o
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] win;
    logic [IW-1:0] id_q [MAX_OUTSTANDING];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          orphan_q, hs, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifndef CV32E40P_APU_ARB_FIXED_PRIO_EN
    logic [IW-1:0] rr_q;
`endif

    // Lowest requester wins by default; in RR mode a requester at or after the
    // pointer overrides it, which gives the wrap-around search order.
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_apu_req_i[i]) win = IW'(i);
`ifndef CV32E40P_APU_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_apu_req_i[i] && IW'(i) >= rr_q) win = IW'(i);
`endif
    end

    assign fpu_req_o        = rst_ni & (|req_apu_req_i) & (count_q < CW'(MAX_OUTSTANDING));
    assign hs               = fpu_req_o & fpu_gnt_i;
    assign pop              = rst_ni & fpu_rvalid_i & (count_q != '0);
    assign req_apu_gnt_o    = hs ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
    assign req_apu_rvalid_o = pop ? {{(NUM_REQ-1){1'b0}}, 1'b1} << id_q[head_q] : '0;
    assign req_apu_result_o = fpu_result_i;
    assign req_apu_rflags_o = fpu_rflags_i;
    assign fpu_operands_o   = req_apu_operands_i[win];
    assign fpu_op_o         = req_apu_op_i[win];
    assign fpu_flags_o      = req_apu_flags_i[win];
    assign fpu_clk_en_o     = rst_ni & ((|req_apu_req_i) | (count_q != '0));
    assign outstanding_o    = count_q;
    assign orphan_err_o     = orphan_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            if (hs) tail_q <= ptr_inc(tail_q);
            if (pop) head_q <= ptr_inc(head_q);
            count_q <= count_q + CW'(hs) - CW'(pop);
            if (fpu_rvalid_i && count_q == '0) orphan_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (hs) id_q[tail_q] <= win;
    end

`ifndef CV32E40P_APU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) rr_q <= '0;
        else if (hs) rr_q <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
`endif
endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// tb_cv32e40p_apu_arbiter: directed vector table, hold sequence and random run against a queue-based model
module tb_cv32e40p_apu_arbiter;
    localparam int N = 2, M = 4, NA = 3, WOP = 6, NDS = 15, NUS = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst_n;
    logic [N-1:0]                req, gnt_o, rv_o;
    logic [N-1:0][NA-1:0][31:0]  ops;
    logic [N-1:0][WOP-1:0]       opc;
    logic [N-1:0][NDS-1:0]       fl;
    logic [31:0]                 res_o, fres;
    logic [NUS-1:0]              rfl_o, frfl;
    logic                        freq, fgnt, frv, clk_en, orph;
    logic [NA-1:0][31:0]         fops;
    logic [WOP-1:0]              fop;
    logic [NDS-1:0]              ffl;
    logic [2:0]                  outst;

    int n_chk = 0, n_fail = 0;
    int q[$];
    int rr = 0;
    bit m_orph = 1'b0;

    cv32e40p_apu_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_apu_req_i(req), .req_apu_gnt_o(gnt_o),
        .req_apu_operands_i(ops), .req_apu_op_i(opc), .req_apu_flags_i(fl),
        .req_apu_rvalid_o(rv_o), .req_apu_result_o(res_o), .req_apu_rflags_o(rfl_o),
        .fpu_req_o(freq), .fpu_gnt_i(fgnt),
        .fpu_operands_o(fops), .fpu_op_o(fop), .fpu_flags_o(ffl),
        .fpu_rvalid_i(frv), .fpu_result_i(fres), .fpu_rflags_i(frfl),
        .fpu_clk_en_o(clk_en), .outstanding_o(outst), .orphan_err_o(orph)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Inputs are settled; compare every output with the model, then advance one clock.
    task automatic cyc();
        int w, start;
        bit f, hsk, pp;
        logic [N-1:0] eg, er;
        w = -1;
`ifdef CV32E40P_APU_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = rr;
`endif
        for (int k = 0; k < N; k++)
            if (w < 0 && req[(start + k) % N]) w = (start + k) % N;
        f   = rst_n && (req != '0) && (q.size() < M);
        hsk = f && fgnt;
        pp  = rst_n && frv && (q.size() > 0);
        eg  = '0;
        er  = '0;
        if (hsk) eg[w] = 1'b1;
        if (pp) er[q[0]] = 1'b1;
        chk("fpu_req", freq, f);
        chk("gnt", gnt_o, eg);
        chk("rvalid", rv_o, er);
        chk("clk_en", clk_en, rst_n && (req != '0 || q.size() > 0));
        chk("outstanding", outst, q.size());
        chk("orphan", orph, m_orph);
        if (f) begin
            chk("payload_ops", fops, ops[w]);
            chk("payload_op", fop, opc[w]);
            chk("payload_flags", ffl, fl[w]);
        end
        if (pp) begin
            chk("result", res_o, fres);
            chk("rflags", rfl_o, frfl);
        end
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            rr = 0;
            m_orph = 1'b0;
        end else begin
            if (frv && q.size() == 0) m_orph = 1'b1;
            if (pp) void'(q.pop_front());
            if (hsk) begin
                q.push_back(w);
                rr = (w + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst_n;
        logic [1:0]  req;
        bit          g;
        bit          rv;
        logic [31:0] res;
        logic [1:0]  eg;
        logic [1:0]  er;
        bit          ef;
        int          eo;
        bit          eorph;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, logic [1:0] rq, bit g, bit rv, logic [31:0] rs,
                               logic [1:0] eg, logic [1:0] er, bit ef, int eo, bit eor);
        vec_t t;
        t = '{r, rq, g, rv, rs, eg, er, ef, eo, eor};
        return t;
    endfunction

    task automatic rand_payload();
        for (int c = 0; c < N; c++) begin
            for (int a = 0; a < NA; a++) ops[c][a] = $urandom;
            opc[c] = WOP'($urandom);
            fl[c]  = NDS'($urandom);
        end
        fres = $urandom;
        frfl = NUS'($urandom);
    endtask

    initial begin
        logic [WOP-1:0] held;
        rst_n = 1'b0; req = '0; fgnt = 1'b0; frv = 1'b0;
        rand_payload();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset, single request latency
        tbl.push_back(v(0, 2'b11, 1, 0, 0,     2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 2'b01, 1, 0, 0,     2'b01, 2'b00, 1, 0, 0));
        tbl.push_back(v(1, 2'b00, 0, 0, 0,     2'b00, 2'b00, 0, 1, 0));
        tbl.push_back(v(1, 2'b00, 0, 0, 0,     2'b00, 2'b00, 0, 1, 0));
        tbl.push_back(v(1, 2'b00, 0, 1, 32'hA, 2'b00, 2'b01, 0, 1, 0));
        tbl.push_back(v(1, 2'b00, 0, 0, 0,     2'b00, 2'b00, 0, 0, 0));
        // fairness then back-pressure at full
        tbl.push_back(v(0, 2'b00, 0, 0, 0,     2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 2'b11, 1, 0, 0,     2'b01, 2'b00, 1, 0, 0));
        tbl.push_back(v(1, 2'b11, 1, 0, 0,     2'b10, 2'b00, 1, 1, 0));
        tbl.push_back(v(1, 2'b11, 1, 0, 0,     2'b01, 2'b00, 1, 2, 0));
        tbl.push_back(v(1, 2'b11, 1, 0, 0,     2'b10, 2'b00, 1, 3, 0));
        tbl.push_back(v(1, 2'b11, 1, 0, 0,     2'b00, 2'b00, 0, 4, 0));
        tbl.push_back(v(1, 2'b11, 1, 1, 1,     2'b00, 2'b01, 0, 4, 0));
        tbl.push_back(v(1, 2'b11, 1, 0, 0,     2'b01, 2'b00, 1, 3, 0));
        tbl.push_back(v(1, 2'b00, 0, 1, 2,     2'b00, 2'b10, 0, 4, 0));
        tbl.push_back(v(1, 2'b00, 0, 1, 3,     2'b00, 2'b01, 0, 3, 0));
        // simultaneous grant and result at count 2
        tbl.push_back(v(1, 2'b01, 1, 1, 4,     2'b01, 2'b10, 1, 2, 0));
        tbl.push_back(v(1, 2'b00, 0, 0, 0,     2'b00, 2'b00, 0, 2, 0));
        tbl.push_back(v(1, 2'b00, 0, 1, 5,     2'b00, 2'b01, 0, 2, 0));
        tbl.push_back(v(1, 2'b00, 0, 1, 6,     2'b00, 2'b01, 0, 1, 0));
        // orphan result
        tbl.push_back(v(1, 2'b00, 0, 1, 7,     2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 2'b00, 0, 0, 0,     2'b00, 2'b00, 0, 0, 1));
        // reset mid-operation at count 3
        tbl.push_back(v(1, 2'b10, 1, 0, 0,     2'b10, 2'b00, 1, 0, 1));
        tbl.push_back(v(1, 2'b10, 1, 0, 0,     2'b10, 2'b00, 1, 1, 1));
        tbl.push_back(v(1, 2'b01, 1, 0, 0,     2'b01, 2'b00, 1, 2, 1));
        tbl.push_back(v(0, 2'b11, 1, 1, 8,     2'b00, 2'b00, 0, 3, 1));
        tbl.push_back(v(1, 2'b11, 1, 0, 0,     2'b01, 2'b00, 1, 0, 0));
        tbl.push_back(v(1, 2'b00, 0, 1, 9,     2'b00, 2'b01, 0, 1, 0));
        tbl.push_back(v(1, 2'b00, 0, 0, 0,     2'b00, 2'b00, 0, 0, 0));
        // routing order c0,c1,c1,c0
        tbl.push_back(v(1, 2'b01, 1, 0, 0,     2'b01, 2'b00, 1, 0, 0));
        tbl.push_back(v(1, 2'b10, 1, 0, 0,     2'b10, 2'b00, 1, 1, 0));
        tbl.push_back(v(1, 2'b10, 1, 0, 0,     2'b10, 2'b00, 1, 2, 0));
        tbl.push_back(v(1, 2'b01, 1, 0, 0,     2'b01, 2'b00, 1, 3, 0));
        tbl.push_back(v(1, 2'b00, 0, 1, 32'hA, 2'b00, 2'b01, 0, 4, 0));
        tbl.push_back(v(1, 2'b00, 0, 1, 32'hB, 2'b00, 2'b10, 0, 3, 0));
        tbl.push_back(v(1, 2'b00, 0, 1, 32'hC, 2'b00, 2'b10, 0, 2, 0));
        tbl.push_back(v(1, 2'b00, 0, 1, 32'hD, 2'b00, 2'b01, 0, 1, 0));
        tbl.push_back(v(1, 2'b00, 0, 0, 0,     2'b00, 2'b00, 0, 0, 0));

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; req = tbl[i].req; fgnt = tbl[i].g;
            frv = tbl[i].rv; fres = tbl[i].res;
            #1;
            chk($sformatf("tbl%0d_gnt", i), gnt_o, tbl[i].eg);
            chk($sformatf("tbl%0d_rvalid", i), rv_o, tbl[i].er);
            chk($sformatf("tbl%0d_fpu_req", i), freq, tbl[i].ef);
            chk($sformatf("tbl%0d_outstanding", i), outst, tbl[i].eo);
            chk($sformatf("tbl%0d_orphan", i), orph, tbl[i].eorph);
            if (tbl[i].rv) chk($sformatf("tbl%0d_result", i), res_o, tbl[i].res);
            cyc();
        end

        // payload held while the FPU stalls the grant
        req = 2'b01; fgnt = 1'b0; frv = 1'b0;
        held = opc[0];
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_op", fop, held);
            chk("hold_gnt", gnt_o, 2'b00);
            cyc();
        end
        fgnt = 1'b1;
        #1;
        chk("hold_release_gnt", gnt_o, 2'b01);
        cyc();
        req = 2'b00; fgnt = 1'b0; frv = 1'b1;
        #1;
        chk("hold_drain_rvalid", rv_o, 2'b01);
        cyc();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            req   = N'($urandom);
            fgnt  = ($urandom_range(0, 3) != 0);
            frv   = ($urandom_range(0, 2) == 0);
            rand_payload();
            #1;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
